// File: rtl/alu_pkg.sv
// Shared types and default sizing for the ALU shift stage.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROL = 2'b11
  } shift_op_t;

endpackage

// File: rtl/alu_shift_stage_if.sv
// Request/result handshake bundle for alu_shift_stage.
// The master drives requests and consumes results; the slave is the shift stage.
interface alu_shift_stage_if #(
  parameter int WIDTH   = alu_pkg::ALU_WIDTH,
  parameter int SHIFT_W = WIDTH
);
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [SHIFT_W-1:0] in_shift;
  shift_op_t          in_op;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_y;
  logic               out_carry;
  logic               out_zero;

  modport master (
    output in_valid, in_a, in_shift, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_shift, in_op, out_ready,
    output in_ready, out_valid, out_y, out_carry, out_zero
  );

endinterface

// File: rtl/left_logic_shifter.sv
// Combinational logical left shift; amounts of WIDTH or more yield zero.
module left_logic_shifter #(
  parameter int WIDTH   = alu_pkg::ALU_WIDTH,
  parameter int SHIFT_W = WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHIFT_W-1:0] shift,
  output logic [WIDTH-1:0]   y
);

  assign y = a << shift;

endmodule

// File: rtl/alu_shift_stage.sv
// Two-stage registered shift unit (LSL/LSR/ASR/ROL) with valid/ready on both sides.
// Define SHIFT_STAGE_ROTATE_EN to enable ROL; otherwise op 11 returns zero.
module alu_shift_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHIFT_W = WIDTH
) (
  input logic              clk,
  input logic              rst,
  alu_shift_stage_if.slave bus
);

  // Shift amount is widened so comparisons against WIDTH never truncate.
  localparam int                CW    = (SHIFT_W > 32) ? SHIFT_W : 32;
  localparam logic [CW-1:0]     W_EXT = CW'(WIDTH);
  localparam logic [WIDTH-1:0]  MSB   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  LSB   = WIDTH'(1);

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [SHIFT_W-1:0] s1_shift;
  shift_op_t          s1_op;

  logic               s2_take;
  logic [CW-1:0]      amt;
  logic               amt_zero;
  logic               amt_big;
  logic               amt_in_range;
  logic [WIDTH-1:0]   lsl_y;
  logic [WIDTH-1:0]   res_y;
  logic               res_carry;
`ifdef SHIFT_STAGE_ROTATE_EN
  logic [CW-1:0]      rot;
`endif

  assign s2_take      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_take;

  assign amt          = CW'(s1_shift);
  assign amt_zero     = (amt == '0);
  assign amt_big      = (amt >= W_EXT);
  assign amt_in_range = !amt_zero && (amt <= W_EXT);

  left_logic_shifter #(
    .WIDTH   (WIDTH),
    .SHIFT_W (CW)
  ) u_lsl (
    .a     (s1_a),
    .shift (amt),
    .y     (lsl_y)
  );

  // Carry is the last bit pushed out, found by shifting one position less.
  always_comb begin
    res_y     = s1_a;
    res_carry = 1'b0;
`ifdef SHIFT_STAGE_ROTATE_EN
    rot       = amt % W_EXT;
`endif
    case (s1_op)
      SH_LSL: begin
        res_y = lsl_y;
        if (amt_in_range)
          res_carry = |((s1_a << (amt - CW'(1))) & MSB);
      end
      SH_LSR: begin
        res_y = s1_a >> amt;
        if (amt_in_range)
          res_carry = |((s1_a >> (amt - CW'(1))) & LSB);
      end
      SH_ASR: begin
        res_y = $unsigned($signed(s1_a) >>> amt);
        if (amt_big)
          res_carry = s1_a[WIDTH-1];
        else if (!amt_zero)
          res_carry = |((s1_a >> (amt - CW'(1))) & LSB);
      end
      SH_ROL: begin
`ifdef SHIFT_STAGE_ROTATE_EN
        if (rot != '0) begin
          res_y     = (s1_a << rot) | (s1_a >> (W_EXT - rot));
          res_carry = res_y[0];
        end
`else
        res_y     = '0;
        res_carry = 1'b0;
`endif
      end
      default: begin
        res_y     = '0;
        res_carry = 1'b0;
      end
    endcase
  end

  // Stage 1: request slice, emptied when its entry moves on to stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_shift <= '0;
      s1_op    <= SH_LSL;
    end else begin
      if (bus.in_ready)
        s1_valid <= bus.in_valid;
      if (bus.in_valid && bus.in_ready) begin
        s1_a     <= bus.in_a;
        s1_shift <= bus.in_shift;
        s1_op    <= bus.in_op;
      end
    end
  end

  // Stage 2: result slice, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_y     <= '0;
      bus.out_carry <= 1'b0;
      bus.out_zero  <= 1'b0;
    end else begin
      if (s2_take)
        bus.out_valid <= s1_valid;
      if (s1_valid && s2_take) begin
        bus.out_y     <= res_y;
        bus.out_carry <= res_carry;
        bus.out_zero  <= (res_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_stage.sv
// Self-checking bench for alu_shift_stage (WIDTH=4); honours SHIFT_STAGE_ROTATE_EN.
module tb_alu_shift_stage;
  import alu_pkg::*;

  localparam int W  = 4;
  localparam int SW = 4;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];

  alu_shift_stage_if #(.WIDTH(W), .SHIFT_W(SW)) bus ();

  alu_shift_stage #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: shift rules evaluated on plain integers.
  function automatic exp_t ref_model(int a, int s, int op);
    exp_t r;
    int mask = (1 << W) - 1;
    int y = 0;
    int c = 0;
    int sa;
    int k;
    a = a & mask;
    case (op)
      0: begin
        y = (s >= W) ? 0 : ((a << s) & mask);
        if (s >= 1 && s <= W) c = (a >> (W - s)) & 1;
      end
      1: begin
        y = (s >= W) ? 0 : (a >> s);
        if (s >= 1 && s <= W) c = (a >> (s - 1)) & 1;
      end
      2: begin
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        if (s >= W) begin
          y = (sa < 0) ? mask : 0;
          c = (sa < 0) ? 1 : 0;
        end else begin
          y = (sa >>> s) & mask;
          c = (s >= 1) ? ((a >> (s - 1)) & 1) : 0;
        end
      end
      default: begin
`ifdef SHIFT_STAGE_ROTATE_EN
        k = s % W;
        y = (k == 0) ? a : (((a << k) | (a >> (W - k))) & mask);
        c = (k != 0) ? (y & 1) : 0;
`else
        k = 0;
        y = 0;
        c = 0;
`endif
      end
    endcase
    r.y = W'(y);
    r.c = c[0];
    r.z = (y == 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offer one request, wait (bounded) for acceptance, then log its expected result.
  task automatic send(input int a, input int s, input int op, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = W'(a);
    bus.in_shift = SW'(s);
    bus.in_op    = shift_op_t'(op[1:0]);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) break;
      waited++;
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
    check("send_accept", acc, 1);
    if (acc) exp_q.push_back(ref_model(a, s, op));
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_now(input string tag, input int y, input int c, input int z);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_y"}, bus.out_y, y);
    check({tag, "_carry"}, bus.out_carry, c);
    check({tag, "_zero"}, bus.out_zero, z);
  endtask

  // Scoreboard: every consumed result must match the oldest accepted request.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("result_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_y", bus.out_y, e.y);
        check("sb_carry", bus.out_carry, e.c);
        check("sb_zero", bus.out_zero, e.z);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int w;
    int ra, rs, rop;
    exp_t held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_shift  = '0;
    bus.in_op     = SH_LSL;
    bus.out_ready = 1'b1;

    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_carry", bus.out_carry, 0);
    check("rst_out_zero", bus.out_zero, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Basic ops and latency
    send(4'b0101, 1, 0, w);
    check("lat_not_early", bus.out_valid, 0);
    expect_now("lsl_5_1", 4'b1010, 0, 0);
    send(4'b1111, 5, 0, w);
    expect_now("lsl_f_5", 4'b0000, 0, 1);
    send(4'b1011, 2, 1, w);
    expect_now("lsr_b_2", 4'b0010, 1, 0);
    send(4'b1000, 2, 2, w);
    expect_now("asr_8_2", 4'b1110, 0, 0);
    send(4'b1000, 7, 2, w);
    expect_now("asr_8_7", 4'b1111, 1, 0);
    send(4'b1001, 1, 3, w);
`ifdef SHIFT_STAGE_ROTATE_EN
    expect_now("rol_9_1", 4'b0011, 1, 0);
`else
    expect_now("rol_9_1", 4'b0000, 0, 1);
`endif
    @(posedge clk);
    #1;

    // Back-to-back at full throughput
    for (int i = 0; i < 4; i++) begin
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), w);
      check("b2b_no_stall", w, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b_drained", exp_q.size(), 0);

    // Backpressure: two accepted, third stalls with outputs frozen
    bus.out_ready = 1'b0;
    send(4'b0011, 1, 0, w);
    check("bp_first_no_stall", w, 0);
    send(4'b1100, 2, 1, w);
    check("bp_second_no_stall", w, 0);
    held = exp_q[0];
    bus.in_valid = 1'b1;
    bus.in_a     = 4'b1010;
    bus.in_shift = 4'd3;
    bus.in_op    = SH_ASR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_out_valid_held", bus.out_valid, 1);
      check("bp_out_y_held", bus.out_y, held.y);
      check("bp_out_carry_held", bus.out_carry, held.c);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    exp_q.push_back(ref_model(4'b1010, 3, 2));
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", exp_q.size(), 0);

    // Randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      ra  = $urandom_range(0, 15);
      rs  = $urandom_range(0, 15);
      rop = $urandom_range(0, 3);
      send(ra, rs, rop, w);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);

    // Reset with both stages occupied
    bus.out_ready = 1'b0;
    send(4'b0110, 1, 0, w);
    send(4'b0111, 2, 1, w);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_y", bus.out_y, 0);
    exp_q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("midrst_no_stale_a", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("midrst_no_stale_b", bus.out_valid, 0);
    send(4'b1001, 1, 1, w);
    expect_now("midrst_new", 4'b0100, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
